// File: rtl/kbd_matrix_scan.sv
// Oric keyboard matrix scanner producing PS/2 set-2 make/break events.
// Optional debounce (two agreeing scans) when KBD_SCAN_DEBOUNCE_EN is defined.
module kbd_matrix_scan #(
    parameter int SETTLE_CYC = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       scan_tick,
    output logic [2:0] col,
    input  logic [7:0] row_in,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic       evt_pressed,
    output logic       evt_extended,
    output logic [7:0] evt_code
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    localparam logic [1:0] S_WAIT   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_CMP    = 2'd3;

    // {extended, code} indexed by {col, row}
    function automatic logic [8:0] keymap(input logic [5:0] idx);
        logic [8:0] k;
        k = 9'h000;
        case (idx)
            6'o00: k = 9'h026;
            6'o01: k = 9'h022;
            6'o02: k = 9'h016;
            6'o03: k = 9'h00E;
            6'o04: k = 9'h02A;
            6'o05: k = 9'h02E;
            6'o06: k = 9'h031;
            6'o07: k = 9'h03D;
            6'o10: k = 9'h023;
            6'o11: k = 9'h015;
            6'o12: k = 9'h076;
            6'o13: k = 9'h00D;
            6'o14: k = 9'h02B;
            6'o15: k = 9'h02D;
            6'o16: k = 9'h02C;
            6'o17: k = 9'h03B;
            6'o20: k = 9'h021;
            6'o21: k = 9'h01E;
            6'o22: k = 9'h01A;
            6'o23: k = 9'h014;
            6'o24: k = 9'h025;
            6'o25: k = 9'h032;
            6'o26: k = 9'h036;
            6'o27: k = 9'h03A;
            6'o30: k = 9'h052;
            6'o31: k = 9'h05D;
            6'o32: k = 9'h058;
            6'o33: k = 9'h111;
            6'o34: k = 9'h04E;
            6'o35: k = 9'h04C;
            6'o36: k = 9'h046;
            6'o37: k = 9'h042;
            6'o40: k = 9'h029;
            6'o41: k = 9'h041;
            6'o42: k = 9'h049;
            6'o43: k = 9'h175;
            6'o44: k = 9'h012;
            6'o45: k = 9'h16B;
            6'o46: k = 9'h172;
            6'o47: k = 9'h174;
            6'o50: k = 9'h03C;
            6'o51: k = 9'h043;
            6'o52: k = 9'h044;
            6'o53: k = 9'h04D;
            6'o54: k = 9'h054;
            6'o55: k = 9'h171;
            6'o56: k = 9'h05B;
            6'o57: k = 9'h066;
            6'o60: k = 9'h01D;
            6'o61: k = 9'h01B;
            6'o62: k = 9'h024;
            6'o63: k = 9'h034;
            6'o64: k = 9'h033;
            6'o65: k = 9'h01C;
            6'o66: k = 9'h035;
            6'o67: k = 9'h03E;
            6'o70: k = 9'h045;
            6'o71: k = 9'h04A;
            6'o72: k = 9'h059;
            6'o73: k = 9'h055;
            6'o74: k = 9'h04B;
            6'o75: k = 9'h05A;
            6'o76: k = 9'h11F;
            6'o77: k = 9'h005;
            default: k = 9'h000;
        endcase
        return k;
    endfunction

    logic [1:0] state;
    logic [3:0] settle_cnt;
    logic [2:0] bit_idx;
    logic [7:0] sample [8];
    logic [7:0] stable [8];
`ifdef KBD_SCAN_DEBOUNCE_EN
    logic [7:0] prev [8];
`endif

    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [9:0]    last_head;
    logic [9:0]    head;

    logic       cur_bit;
    logic       chg;
    logic       in_cmp;
    logic       full;
    logic       pop;
    logic       push;
    logic       stall;
    logic [9:0] push_data;

    always_comb begin
        cur_bit = sample[col][bit_idx];
`ifdef KBD_SCAN_DEBOUNCE_EN
        chg = (cur_bit == prev[col][bit_idx]) &&
              (cur_bit != stable[col][bit_idx]);
`else
        chg = cur_bit != stable[col][bit_idx];
`endif
        in_cmp    = state == S_CMP;
        full      = count == DEPTH_C;
        evt_valid = count != '0;
        pop       = evt_valid && evt_ready;
        // a full FIFO still accepts a push when it pops in the same cycle
        push      = in_cmp && chg && (!full || pop);
        stall     = in_cmp && chg && !push;
        push_data = {cur_bit, keymap({col, bit_idx})};
        head      = evt_valid ? mem[rd_ptr] : last_head;
    end

    assign {evt_pressed, evt_extended, evt_code} = head;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_WAIT;
            col        <= '0;
            settle_cnt <= '0;
            bit_idx    <= '0;
            for (int i = 0; i < 8; i++) begin
                sample[i] <= '0;
                stable[i] <= '0;
`ifdef KBD_SCAN_DEBOUNCE_EN
                prev[i]   <= '0;
`endif
            end
        end else begin
            case (state)
                S_WAIT: begin
                    if (scan_tick) begin
                        state      <= S_SETTLE;
                        settle_cnt <= '0;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state      <= S_SAMPLE;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    sample[col] <= row_in;
`ifdef KBD_SCAN_DEBOUNCE_EN
                    prev[col]   <= sample[col];
`endif
                    bit_idx     <= '0;
                    state       <= S_CMP;
                end
                S_CMP: begin
                    if (!stall) begin
                        if (push) begin
                            stable[col][bit_idx] <= cur_bit;
                        end
                        if (bit_idx == 3'd7) begin
                            col   <= col + 3'd1;
                            state <= S_WAIT;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                default: state <= S_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_head <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // remembered so the outputs keep the last head once drained
            if (evt_valid) begin
                last_head <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_kbd_matrix_scan.sv
// Scoreboard bench for kbd_matrix_scan with a key-level reference model.
// Honours KBD_SCAN_DEBOUNCE_EN in the model exactly as the design does.
module tb_kbd_matrix_scan;

    localparam int SETTLE = 4;
    localparam int DEPTH  = 8;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       scan_tick = 1'b0;
    logic       evt_ready = 1'b0;
    logic [2:0] col;
    logic [7:0] row_in;
    logic       evt_valid;
    logic       evt_pressed;
    logic       evt_extended;
    logic [7:0] evt_code;

    logic [7:0] matrix [8];
    assign row_in = matrix[col];

    always #5 clk_sys = ~clk_sys;

    kbd_matrix_scan #(
        .SETTLE_CYC(SETTLE),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .scan_tick   (scan_tick),
        .col         (col),
        .row_in      (row_in),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_pressed (evt_pressed),
        .evt_extended(evt_extended),
        .evt_code    (evt_code)
    );

    // PS/2 set-2 {extended, code} per key, index = col*8 + row
    logic [8:0] km [64] = '{
        9'h026, 9'h022, 9'h016, 9'h00E, 9'h02A, 9'h02E, 9'h031, 9'h03D,
        9'h023, 9'h015, 9'h076, 9'h00D, 9'h02B, 9'h02D, 9'h02C, 9'h03B,
        9'h021, 9'h01E, 9'h01A, 9'h014, 9'h025, 9'h032, 9'h036, 9'h03A,
        9'h052, 9'h05D, 9'h058, 9'h111, 9'h04E, 9'h04C, 9'h046, 9'h042,
        9'h029, 9'h041, 9'h049, 9'h175, 9'h012, 9'h16B, 9'h172, 9'h174,
        9'h03C, 9'h043, 9'h044, 9'h04D, 9'h054, 9'h171, 9'h05B, 9'h066,
        9'h01D, 9'h01B, 9'h024, 9'h034, 9'h033, 9'h01C, 9'h035, 9'h03E,
        9'h045, 9'h04A, 9'h059, 9'h055, 9'h04B, 9'h05A, 9'h11F, 9'h005
    };

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [9:0] exp_q [$];
    logic [9:0] last_evt = '0;
    bit         m_stable [64];
    bit         m_prev [64];
    int         m_col = 0;
    int         ready_mode = 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    always @(posedge clk_sys) begin
        #2;
        if (ready_mode == 2) evt_ready = 1'($urandom_range(0, 1));
        else evt_ready = (ready_mode == 1);
    end

    always @(negedge clk_sys) begin
        logic [9:0] e;
        if (reset_n) begin
            if (evt_valid) begin
                if (evt_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_evt",
                            32'({evt_pressed, evt_extended, evt_code}),
                            32'h400);
                    end else begin
                        e = exp_q.pop_front();
                        chk("evt", 32'({evt_pressed, evt_extended, evt_code}),
                            32'(e));
                        last_evt = e;
                    end
                end
            end else begin
                chk("idle_hold", 32'({evt_pressed, evt_extended, evt_code}),
                    32'(last_evt));
            end
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_pressed", 32'(evt_pressed), 0);
        chk("rst_ext", 32'(evt_extended), 0);
        chk("rst_code", 32'(evt_code), 0);
        chk("rst_col", 32'(col), 0);
        for (int i = 0; i < 64; i++) begin
            m_stable[i] = 1'b0;
            m_prev[i]   = 1'b0;
        end
        exp_q.delete();
        last_evt = '0;
        m_col    = 0;
        reset_n  = 1'b1;
    endtask

    task automatic wait_col(input int exp, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk_sys);
            #1;
            if (int'(col) == exp) ok = 1'b1;
        end
        chk("col_step", 32'(col), 32'(exp));
    endtask

    task automatic do_scan(input bit abort_on_stall, output bit stalled);
        logic [9:0] evs [$];
        int         c;
        int         k;
        bit         nb;
        bit         fire;
        c = m_col;
        for (int r = 0; r < 8; r++) begin
            k  = c * 8 + r;
            nb = matrix[c][r];
`ifdef KBD_SCAN_DEBOUNCE_EN
            fire = (nb == m_prev[k]) && (nb != m_stable[k]);
            m_prev[k] = nb;
`else
            fire = nb != m_stable[k];
`endif
            if (fire) begin
                m_stable[k] = nb;
                evs.push_back({nb, km[k]});
            end
        end
        stalled = (ready_mode == 0) && (exp_q.size() + evs.size() > DEPTH);
        foreach (evs[i]) exp_q.push_back(evs[i]);
        m_col = (c + 1) % 8;
        @(posedge clk_sys);
        #1 scan_tick = 1'b1;
        @(posedge clk_sys);
        #1 scan_tick = 1'b0;
        if ($urandom_range(0, 1) == 1) begin
            scan_tick = 1'b1;
            @(posedge clk_sys);
            #1 scan_tick = 1'b0;
        end
        if (stalled) begin
            repeat (SETTLE + 30) @(posedge clk_sys);
            #1;
            chk("stall_col", 32'(col), 32'(c));
            chk("stall_valid", 32'(evt_valid), 1);
            if (abort_on_stall) return;
            ready_mode = 1;
        end
        wait_col(m_col, 400);
    endtask

    task automatic drain();
        ready_mode = 1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clk_sys);
        end
        repeat (3) @(posedge clk_sys);
        #1;
        chk("drain_left", 32'(exp_q.size()), 0);
        chk("drain_valid", 32'(evt_valid), 0);
    endtask

    task automatic scans(input int n);
        bit st;
        repeat (n) do_scan(1'b0, st);
    endtask

    initial begin
        bit st;
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit st;
        for (int i = 0; i < 8; i++) matrix[i] = 8'h00;
        ready_mode = 1;
        do_reset();

        scans(8);
        chk("col_wrap", 32'(col), 0);

        matrix[7] = 8'h20;
        scans(16);
        matrix[7] = 8'h00;
        scans(16);
        drain();

        matrix[4] = 8'h89;
        scans(16);
        matrix[4] = 8'h00;
        scans(16);
        drain();

        matrix[2] = 8'h10;
        scans(8);
        matrix[2] = 8'h00;
        scans(16);
        drain();

        do_reset();
        ready_mode = 0;
        matrix[0] = 8'hFF;
        matrix[1] = 8'h03;
        scans(16);
        matrix[0] = 8'h00;
        matrix[1] = 8'h00;
        scans(16);
        drain();

        do_reset();
        ready_mode = 0;
        matrix[0] = 8'hFF;
        matrix[1] = 8'h01;
        st = 1'b0;
        for (int i = 0; i < 16 && !st; i++) do_scan(1'b1, st);
        reset_n = 1'b0;
        #1;
        chk("abort_valid", 32'(evt_valid), 0);
        chk("abort_col", 32'(col), 0);
        do_reset();
        ready_mode = 1;
        scans(16);
        matrix[0] = 8'h00;
        matrix[1] = 8'h00;
        scans(16);
        drain();

        ready_mode = 2;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                matrix[$urandom_range(0, 7)] ^= 8'(1 << $urandom_range(0, 7));
            end
            scans(1);
        end
        for (int i = 0; i < 8; i++) matrix[i] = 8'h00;
        scans(16);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end

endmodule
